// File: rtl/seg_scan.sv
// Multiplexed driver for a bank of active-low common-anode seven-segment digits.
// Latches hex value and dp/blank masks, scans one digit per DIV cycles, registered outputs.
module seg_scan #(
   parameter int unsigned DIGITS = 8,
   parameter int unsigned DIV    = 1000,
   localparam int unsigned IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic                  lz_en,
   input  logic                  enable,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic [IW-1:0]         digit_idx
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned VW = 4 * DIGITS;

   logic [VW-1:0]     val_q,  val_d;
   logic [DIGITS-1:0] dp_q,   dp_d;
   logic [DIGITS-1:0] blk_q,  blk_d;
   logic [PW-1:0]     pre_q,  pre_d;
   logic [IW-1:0]     idx_q,  idx_d;
   logic [7:0]        seg_q,  seg_d;
   logic [DIGITS-1:0] an_q,   an_d;
   logic [IW-1:0]     didx_q, didx_d;

   // Active-high glyph, bit7=a .. bit1=g, bit0=dp
   function automatic logic [7:0] glyph(input logic [3:0] n);
      logic [7:0] p;
      case (n)
         4'h0: p = 8'hFC;  4'h1: p = 8'h60;  4'h2: p = 8'hDA;  4'h3: p = 8'hF2;
         4'h4: p = 8'h66;  4'h5: p = 8'hB6;  4'h6: p = 8'hBE;  4'h7: p = 8'hE0;
         4'h8: p = 8'hFE;  4'h9: p = 8'hF6;  4'hA: p = 8'hEE;  4'hB: p = 8'h3E;
         4'hC: p = 8'h9C;  4'hD: p = 8'h7A;  4'hE: p = 8'h9E;  default: p = 8'h8E;
      endcase
      return p;
   endfunction

   // Shadow capture and prescaled digit scan
   always_comb begin
      val_d = val_q;
      dp_d  = dp_q;
      blk_d = blk_q;
      pre_d = pre_q;
      idx_d = idx_q;
      if (load) begin
         val_d = value;
         dp_d  = dp_mask;
         blk_d = blank_mask;
      end
      if (enable) begin
         if (pre_q == PW'(DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   logic [DIGITS-1:0] lz_vec;
   logic              lz_acc;
   logic [3:0]        nib;
   logic              dark;
   logic [7:0]        pat;

   // lz_vec[i]: nibbles i..DIGITS-1 are all zero (digit 0 exempt)
   always_comb begin
      lz_acc = 1'b1;
      lz_vec = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         lz_acc    = lz_acc & (val_q[4*i +: 4] == 4'd0);
         lz_vec[i] = lz_acc;
      end
      lz_vec[0] = 1'b0;
   end

   // Output pattern for the digit currently selected
   always_comb begin
      nib    = 4'(val_q >> {idx_q, 2'b00});
      dark   = !enable || blk_q[idx_q] || (lz_en && lz_vec[idx_q]);
      pat    = glyph(nib) | {7'b0, dp_q[idx_q]};
      seg_d  = dark ? 8'hFF : ~pat;
      an_d   = enable ? ~(DIGITS'(1) << idx_q) : '1;
      didx_d = idx_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q  <= '0;
         dp_q   <= '0;
         blk_q  <= '0;
         pre_q  <= '0;
         idx_q  <= '0;
         seg_q  <= 8'hFF;
         an_q   <= '1;
         didx_q <= '0;
      end else begin
         val_q  <= val_d;
         dp_q   <= dp_d;
         blk_q  <= blk_d;
         pre_q  <= pre_d;
         idx_q  <= idx_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
         didx_q <= didx_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign digit_idx = didx_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan (4 digits, 3-cycle dwell): directed vector table plus random
// stimulus against a frame-position reference model.
module tb_seg_scan;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned DIV    = 3;

   logic        clk, rst_n, load, lz_en, enable;
   logic [15:0] value;
   logic [3:0]  dp_mask, blank_mask;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic [1:0]  digit_idx;

   int checks = 0;
   int errors = 0;

   seg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value),
      .dp_mask(dp_mask), .blank_mask(blank_mask), .lz_en(lz_en),
      .enable(enable), .seg(seg), .an(an), .digit_idx(digit_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   // Reference state: shadow contents plus count of enabled cycles since reset
   logic [15:0] m_val;
   logic [3:0]  m_dp, m_blk;
   int          m_tick;

   typedef struct {
      bit          rst;
      bit          ld;
      logic [15:0] val;
      logic [3:0]  dp;
      logic [3:0]  blk;
      bit          lz;
      bit          en;
      int          reps;
      logic [3:0]  an;
      logic [7:0]  seg;
      logic [1:0]  idx;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit rst, input bit ld, input logic [15:0] val,
                      input logic [3:0] dp, input logic [3:0] blk, input bit lz,
                      input bit en, input int reps, input logic [3:0] a,
                      input logic [7:0] s, input logic [1:0] ix);
      vec_t v;
      v.rst = rst; v.ld = ld; v.val = val; v.dp = dp; v.blk = blk; v.lz = lz;
      v.en = en; v.reps = reps; v.an = a; v.seg = s; v.idx = ix;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      load = 1'b0;
      enable = 1'b0;
      #1;
      chk("rst_seg", seg, 8'hFF);
      chk("rst_an", 8'(an), 8'h0F);
      chk("rst_idx", 8'(digit_idx), 8'h00);
      m_val = '0; m_dp = '0; m_blk = '0; m_tick = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one cycle; returns the outputs the display should show after this edge
   task automatic cyc(input bit ld, input logic [15:0] v, input logic [3:0] d,
                      input logic [3:0] b, input bit lz, input bit en,
                      output logic [3:0] ean, output logic [7:0] eseg,
                      output logic [1:0] eidx);
      int ix;
      bit sup;
      load = ld; value = v; dp_mask = d; blank_mask = b; lz_en = lz; enable = en;
      @(posedge clk);
      ix   = (m_tick / int'(DIV)) % int'(DIGITS);
      sup  = lz && (ix != 0) && ((m_val >> (4 * ix)) == 16'd0);
      eidx = 2'(ix);
      ean  = en ? ~(4'(1) << ix) : 4'hF;
      if (!en || m_blk[ix] || sup) eseg = 8'hFF;
      else eseg = ~(glyph[m_val[4*ix +: 4]] | {7'b0, m_dp[ix]});
      if (ld) begin
         m_val = v; m_dp = d; m_blk = b;
      end
      if (en) m_tick++;
      #1;
      load = 1'b0;
   endtask

   initial begin
      logic [3:0]  ean;
      logic [7:0]  eseg;
      logic [1:0]  eidx;
      logic [15:0] rv;
      logic [3:0]  rb;

      rst_n = 1'b1; load = 1'b0; lz_en = 1'b0; enable = 1'b0;
      value = '0; dp_mask = '0; blank_mask = '0;

      // scan order with value 1A3F
      add(1,1,16'h1A3F,0,0,0,1,1,4'hE,8'h03,0);
      add(0,0,0,0,0,0,1,2,4'hE,8'h71,0);
      add(0,0,0,0,0,0,1,3,4'hD,8'h0D,1);
      add(0,0,0,0,0,0,1,3,4'hB,8'h11,2);
      add(0,0,0,0,0,0,1,3,4'h7,8'h9F,3);
      add(0,0,0,0,0,0,1,3,4'hE,8'h71,0);
      // decimal point and blank
      add(1,1,16'h0008,4'b0001,4'b0100,0,1,1,4'hE,8'h03,0);
      add(0,0,0,0,0,0,1,2,4'hE,8'h00,0);
      add(0,0,0,0,0,0,1,3,4'hD,8'h03,1);
      add(0,0,0,0,0,0,1,3,4'hB,8'hFF,2);
      add(0,0,0,0,0,0,1,3,4'h7,8'h03,3);
      // leading-zero suppression, then all-zero value
      add(1,1,16'h0070,0,0,1,1,1,4'hE,8'h03,0);
      add(0,0,0,0,0,1,1,2,4'hE,8'h03,0);
      add(0,0,0,0,0,1,1,3,4'hD,8'h1F,1);
      add(0,0,0,0,0,1,1,3,4'hB,8'hFF,2);
      add(0,0,0,0,0,1,1,3,4'h7,8'hFF,3);
      add(0,1,16'h0000,0,0,1,1,1,4'hE,8'h03,0);
      add(0,0,0,0,0,1,1,2,4'hE,8'h03,0);
      add(0,0,0,0,0,1,1,3,4'hD,8'hFF,1);
      add(0,0,0,0,0,1,1,3,4'hB,8'hFF,2);
      add(0,0,0,0,0,1,1,3,4'h7,8'hFF,3);
      // enable freeze at digit 2, one cycle into its dwell
      add(1,1,16'h1A3F,0,0,0,1,1,4'hE,8'h03,0);
      add(0,0,0,0,0,0,1,2,4'hE,8'h71,0);
      add(0,0,0,0,0,0,1,3,4'hD,8'h0D,1);
      add(0,0,0,0,0,0,1,1,4'hB,8'h11,2);
      add(0,0,0,0,0,0,0,5,4'hF,8'hFF,2);
      add(0,0,0,0,0,0,1,2,4'hB,8'h11,2);
      add(0,0,0,0,0,0,1,3,4'h7,8'h9F,3);
      add(0,0,0,0,0,0,1,3,4'hE,8'h71,0);
      // load on the wrap edge
      add(1,1,16'h1A3F,0,0,0,1,1,4'hE,8'h03,0);
      add(0,0,0,0,0,0,1,2,4'hE,8'h71,0);
      add(0,0,0,0,0,0,1,3,4'hD,8'h0D,1);
      add(0,0,0,0,0,0,1,3,4'hB,8'h11,2);
      add(0,0,0,0,0,0,1,2,4'h7,8'h9F,3);
      add(0,1,16'h5555,0,0,0,1,1,4'h7,8'h9F,3);
      add(0,0,0,0,0,0,1,1,4'hE,8'h49,0);

      for (int r = 0; r < tbl.size(); r++) begin
         if (tbl[r].rst) do_reset();
         for (int k = 0; k < tbl[r].reps; k++) begin
            cyc(tbl[r].ld && (k == 0), tbl[r].val, tbl[r].dp, tbl[r].blk,
                tbl[r].lz, tbl[r].en, ean, eseg, eidx);
            chk($sformatf("vec%0d.%0d seg", r, k), seg, tbl[r].seg);
            chk($sformatf("vec%0d.%0d an", r, k), 8'(an), 8'(tbl[r].an));
            chk($sformatf("vec%0d.%0d idx", r, k), 8'(digit_idx), 8'(tbl[r].idx));
         end
      end

      // randomized run against the reference model, with one mid-run reset
      do_reset();
      for (int n = 0; n < 800; n++) begin
         if (n == 400) do_reset();
         rv = 16'($urandom);
         if ($urandom_range(1, 0) == 1) rv = rv >> $urandom_range(15, 0);
         rb = ($urandom_range(2, 0) == 0) ? 4'($urandom) : 4'h0;
         cyc($urandom_range(3, 0) == 0, rv, 4'($urandom), rb,
             1'($urandom), $urandom_range(7, 0) != 0, ean, eseg, eidx);
         chk($sformatf("rnd%0d seg", n), seg, eseg);
         chk($sformatf("rnd%0d an", n), 8'(an), 8'(ean));
         chk($sformatf("rnd%0d idx", n), 8'(digit_idx), 8'(eidx));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
